// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and constants for the ATM card/keypad front end
package atm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } atm_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_PARITY    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
  localparam logic [1:0] ERR_SHORT_PIN = 2'd3;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  // 8 data bits followed by one odd-parity bit
  localparam int FRAME_LEN = 9;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_card_frontend_if.sv
// rtl/atm_card_frontend_if.sv - card reader / keypad / session output bundle
interface atm_card_frontend_if #(parameter int PIN_DIGITS = 4);
  logic                    card_present;
  logic                    card_bit_valid;
  logic                    card_bit;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    card_inserted;
  logic [7:0]              card_number;
  logic [4*PIN_DIGITS-1:0] pin_value;
  logic                    pin_ready;
  logic [1:0]              read_error;
  logic [2:0]              digit_count;

  // front end side
  modport slave (
    input  card_present, card_bit_valid, card_bit, key_valid, key_code,
    output card_inserted, card_number, pin_value, pin_ready, read_error, digit_count
  );

  // reader hardware / controller side
  modport master (
    output card_present, card_bit_valid, card_bit, key_valid, key_code,
    input  card_inserted, card_number, pin_value, pin_ready, read_error, digit_count
  );
endinterface

// File: rtl/atm_debounce.sv
// rtl/atm_debounce.sv - level debouncer with registered rise/fall pulses
module atm_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // count consecutive cycles that disagree with the accepted level; any agreement restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (din != level) begin
        if (cnt == LAST) begin
          level <= din;
          rise  <= din;
          fall  <= ~din;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/atm_card_frontend.sv
// rtl/atm_card_frontend.sv - card read, parity/timeout check and PIN collection
module atm_card_frontend
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int READ_TIMEOUT    = 64,
  parameter int PIN_DIGITS      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  atm_card_frontend_if.slave   bus
);

  localparam int            PW        = 4 * PIN_DIGITS;
  localparam int            TW        = $clog2(READ_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(READ_TIMEOUT - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(FRAME_LEN - 1);
  localparam logic [2:0]    DIGIT_MAX = 3'(PIN_DIGITS);

  atm_state_t           state;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] frame_next;
  logic [3:0]           bit_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic                 pin_committed;
  logic                 card_inserted_q;
  logic [7:0]           card_number_q;
  logic [PW-1:0]        pin_value_q;
  logic                 pin_ready_q;
  logic [1:0]           read_error_q;
  logic [2:0]           digit_count_q;
  logic                 card_level;
  logic                 card_rise;
  logic                 card_fall;
  logic                 removal;

  atm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_card_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.card_present),
    .level (card_level),
    .rise  (card_rise),
    .fall  (card_fall)
  );

  // LSB-first: each new bit enters at the top, so the first bit ends at [0]
  assign frame_next = {bus.card_bit, shreg[FRAME_LEN-1:1]};
  assign removal    = card_fall | ~card_level;

  // session FSM; removal is evaluated last so it overrides any same-cycle key or bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      tmo_cnt         <= '0;
      pin_committed   <= 1'b0;
      card_inserted_q <= 1'b0;
      card_number_q   <= '0;
      pin_value_q     <= '0;
      pin_ready_q     <= 1'b0;
      read_error_q    <= ERR_NONE;
      digit_count_q   <= '0;
    end else begin
      pin_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (card_rise) begin
            state         <= ST_READ;
            shreg         <= '0;
            bit_cnt       <= '0;
            tmo_cnt       <= '0;
            pin_committed <= 1'b0;
            read_error_q  <= ERR_NONE;
            digit_count_q <= '0;
            pin_value_q   <= '0;
          end
        end
        ST_READ: begin
          if (bus.card_bit_valid) begin
            shreg   <= frame_next;
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              if (^frame_next) begin
                card_number_q   <= frame_next[7:0];
                card_inserted_q <= 1'b1;
                state           <= ST_ACTIVE;
              end else begin
                read_error_q <= ERR_PARITY;
                state        <= ST_ERROR;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt      <= TMO_LAST + TW'(1);
            read_error_q <= ERR_TIMEOUT;
            state        <= ST_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_ACTIVE: begin
          if (bus.key_valid) begin
            if (is_digit(bus.key_code)) begin
              if (digit_count_q < DIGIT_MAX) begin
                // a previously committed PIN is discarded by the first new digit
                pin_value_q   <= pin_committed ? PW'(bus.key_code)
                                               : {pin_value_q[PW-5:0], bus.key_code};
                pin_committed <= 1'b0;
                digit_count_q <= digit_count_q + 3'd1;
                read_error_q  <= ERR_NONE;
              end
            end else if (bus.key_code == KEY_CLEAR) begin
              pin_value_q   <= '0;
              digit_count_q <= '0;
              read_error_q  <= ERR_NONE;
              pin_committed <= 1'b0;
            end else if (bus.key_code == KEY_ENTER) begin
              if (digit_count_q == DIGIT_MAX) begin
                pin_ready_q   <= 1'b1;
                digit_count_q <= '0;
                pin_committed <= 1'b1;
              end else begin
                read_error_q  <= ERR_SHORT_PIN;
                pin_value_q   <= '0;
                digit_count_q <= '0;
              end
            end
          end
        end
        default: begin
        end
      endcase
      if (removal && state != ST_IDLE) begin
        state           <= ST_IDLE;
        card_inserted_q <= 1'b0;
        card_number_q   <= '0;
        pin_value_q     <= '0;
        digit_count_q   <= '0;
        pin_ready_q     <= 1'b0;
        pin_committed   <= 1'b0;
      end
    end
  end

  assign bus.card_inserted = card_inserted_q;
  assign bus.card_number   = card_number_q;
  assign bus.pin_value     = pin_value_q;
  assign bus.pin_ready     = pin_ready_q;
  assign bus.read_error    = read_error_q;
  assign bus.digit_count   = digit_count_q;

endmodule

// File: tb/tb_atm_card_frontend.sv
// tb/tb_atm_card_frontend.sv - directed self-checking bench for atm_card_frontend
module tb_atm_card_frontend;
  import atm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  atm_card_frontend_if bus ();

  atm_card_frontend #(
    .DEBOUNCE_CYCLES (4),
    .READ_TIMEOUT    (64),
    .PIN_DIGITS      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.card_bit_valid = 1'b1;
    bus.card_bit       = b;
    step();
    bus.card_bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
  endtask

  task automatic hold(input logic p, input int n);
    bus.card_present = p;
    repeat (n) step();
  endtask

  initial begin
    logic [7:0] d;
    logic [6:0] bounce;
    rst_n              = 1'b0;
    bus.card_present   = 1'b0;
    bus.card_bit_valid = 1'b0;
    bus.card_bit       = 1'b0;
    bus.key_valid      = 1'b0;
    bus.key_code       = 4'h0;
    repeat (3) step();
    check("rst_inserted", 16'(bus.card_inserted), 16'h0);
    check("rst_number",   16'(bus.card_number),   16'h0);
    check("rst_pin",      bus.pin_value,          16'h0);
    check("rst_ready",    16'(bus.pin_ready),     16'h0);
    check("rst_error",    16'(bus.read_error),    16'h0);
    check("rst_count",    16'(bus.digit_count),   16'h0);
    rst_n = 1'b1;
    step();

    // good read of card 0x05
    hold(1'b1, 4);
    step();
    d = 8'h05;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    check("good_8bits_not_inserted", 16'(bus.card_inserted), 16'h0);
    send_bit(1'b1);
    check("good_inserted", 16'(bus.card_inserted), 16'h1);
    check("good_number",   16'(bus.card_number),   16'h05);
    check("good_error",    16'(bus.read_error),    16'h0);

    // PIN 1,2,3,4,5,ENTER
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("pin4_value", bus.pin_value, 16'h1234);
    check("pin4_count", 16'(bus.digit_count), 16'd4);
    press(4'd5);
    check("pin5_ignored", bus.pin_value, 16'h1234);
    press(KEY_ENTER);
    check("enter_ready", 16'(bus.pin_ready),   16'h1);
    check("enter_count", 16'(bus.digit_count), 16'h0);
    check("enter_value", bus.pin_value,        16'h1234);
    step();
    check("ready_one_cycle", 16'(bus.pin_ready), 16'h0);
    check("value_held",      bus.pin_value,      16'h1234);

    // short PIN
    press(4'd9);
    check("reentry_clears", bus.pin_value, 16'h0009);
    press(4'd8);
    press(KEY_ENTER);
    check("short_error", 16'(bus.read_error),  16'h3);
    check("short_pin",   bus.pin_value,        16'h0);
    check("short_count", 16'(bus.digit_count), 16'h0);
    check("short_ready", 16'(bus.pin_ready),   16'h0);

    // 7, CLEAR, 4, (0xC), 3, 2, 1, ENTER
    press(4'd7);
    check("digit_clears_error", 16'(bus.read_error), 16'h0);
    check("digit7",             bus.pin_value,       16'h0007);
    press(KEY_CLEAR);
    check("clear_pin",   bus.pin_value,        16'h0);
    check("clear_count", 16'(bus.digit_count), 16'h0);
    press(4'd4);
    press(4'hC);
    check("undef_key_count", 16'(bus.digit_count), 16'd1);
    check("undef_key_pin",   bus.pin_value,        16'h0004);
    press(4'd3); press(4'd2); press(4'd1);
    press(KEY_ENTER);
    check("pin4321_ready", 16'(bus.pin_ready), 16'h1);
    check("pin4321_value", bus.pin_value,      16'h4321);

    // removal with key 6 pressed in the cycle the fall is acted on
    hold(1'b0, 4);
    check("fall_not_yet", 16'(bus.card_inserted), 16'h1);
    press(4'd6);
    check("rm_inserted", 16'(bus.card_inserted), 16'h0);
    check("rm_number",   16'(bus.card_number),   16'h0);
    check("rm_pin",      bus.pin_value,          16'h0);
    check("rm_count",    16'(bus.digit_count),   16'h0);
    check("rm_ready",    16'(bus.pin_ready),     16'h0);
    step();
    check("rm_key_dropped", bus.pin_value, 16'h0);

    // parity failure
    hold(1'b1, 4);
    step();
    send_frame(8'h05, 1'b0);
    check("par_error",    16'(bus.read_error),    16'h1);
    check("par_inserted", 16'(bus.card_inserted), 16'h0);
    press(4'd1);
    check("error_ignores_key", 16'(bus.digit_count), 16'h0);
    hold(1'b0, 4);
    step();
    check("par_error_retained", 16'(bus.read_error),    16'h1);
    check("par_rm_inserted",    16'(bus.card_inserted), 16'h0);

    // bounce 1,1,0,1,1,1,1: insertion clears read_error only once accepted
    bounce = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      bus.card_present = bounce[i];
      step();
    end
    check("bounce_not_early", 16'(bus.read_error), 16'h1);
    step();
    check("bounce_accepted",  16'(bus.read_error), 16'h0);

    // timeout: 3 bits then stall
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (63) step();
    check("tmo_not_yet", 16'(bus.read_error), 16'h0);
    step();
    check("tmo_error",    16'(bus.read_error),    16'h2);
    check("tmo_inserted", 16'(bus.card_inserted), 16'h0);
    send_frame(8'h05, 1'b1);
    check("error_ignores_bits", 16'(bus.card_inserted), 16'h0);
    check("error_number",       16'(bus.card_number),   16'h0);

    // reset mid-operation, card still present: re-debounce and read 0x3C
    rst_n = 1'b0;
    step();
    check("midrst_error", 16'(bus.read_error), 16'h0);
    rst_n = 1'b1;
    repeat (5) step();
    send_frame(8'h3C, 1'b1);
    check("reread_number",   16'(bus.card_number),   16'h3C);
    check("reread_inserted", 16'(bus.card_inserted), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_card_frontend.md
Name: atm_card_frontend

Overview:
- Card-reader and keypad front end that drives the ATM controller's session inputs.
- Debounces the card-present sensor and deserialises the 8-bit card number from the card's serial track, with a parity check.
- Collects a 4-digit BCD PIN from the keypad.
- Presents `card_inserted`, `card_number` and a stable `pin_value`, which the controller samples during card validation and PIN check.

Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles of `card_present` required before a level change is accepted.
- `READ_TIMEOUT`, 64: cycles allowed between card bits before a read timeout is declared.
- `PIN_DIGITS`, 4: number of BCD digits in a PIN. Fixed at 4; `pin_value` width is 4*`PIN_DIGITS`.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `card_present`  in  1  raw card sensor, asynchronous to logic, already synchronised upstream
- `card_bit_valid`  in  1  one-cycle strobe: `card_bit` is valid this cycle
- `card_bit`  in  1  serial card data, LSB first
- `key_valid`  in  1  one-cycle keypad strobe
- `key_code`  in  4  key value: 0-9 digit, 0xA CLEAR, 0xB ENTER, others ignored
- `card_inserted`  out  1  debounced card presence, qualified by a good read
- `card_number`  out  8  latched card number
- `pin_value`  out  16  BCD PIN; first digit entered sits in [15:12]
- `pin_ready`  out  1  one-cycle pulse when a complete PIN is committed
- `read_error`  out  2  0 none, 1 parity, 2 timeout, 3 short PIN; sticky until the next event clears it
- `digit_count`  out  3  digits currently buffered (0..4)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; debounce counter, bit counter and timeout counter all 0.
- Debounce: a counter runs while `card_present` differs from the accepted level. It commits the new level when the count reaches `DEBOUNCE_CYCLES`-1, so 4 stable cycles commit. Any bounce restarts the count.
- IDLE:
  - On accepted rise: go to READ; clear the bit counter, shift register, `read_error`, `digit_count` and `pin_value`.
- READ:
  - Each `card_bit_valid` shifts `card_bit` in, LSB first, and resets the timeout counter. Frame is 9 bits: 8 data bits, then 1 odd-parity bit.
  - After bit 9:
    - Parity OK: latch `card_number`, assert `card_inserted` on the next cycle, go to ACTIVE.
    - Parity bad: `read_error`=1, go to ERROR.
  - Timeout counter increments on cycles with no bit. Reaching `READ_TIMEOUT` gives `read_error`=2 and goes to ERROR.
- ACTIVE:
  - Digit with `digit_count`<4: `pin_value` <= {`pin_value`[11:0], digit}, `digit_count`++, `read_error` cleared.
  - Digit with `digit_count`==4: ignored.
  - CLEAR: `pin_value`=0, `digit_count`=0, `read_error`=0.
  - ENTER with `digit_count`==4: `pin_ready` pulses for one cycle, `digit_count`<=0, `pin_value` held unchanged so the controller can sample it at any later cycle.
  - ENTER with `digit_count`<4: `read_error`=3, `pin_value` and `digit_count` cleared, no `pin_ready`.
  - The first digit after a committed PIN clears `pin_value` to 0 before shifting in, which supports re-entry after a PIN error.
  - Undefined key codes (0xC-0xF) are ignored.
- ERROR: `card_inserted` stays 0; all inputs other than `card_present` are ignored; waits for the accepted fall.
- Removal: an accepted fall in READ, ACTIVE or ERROR goes to IDLE next cycle and clears `card_inserted`, `card_number`, `pin_value`, `digit_count` and `pin_ready`. `read_error` is retained until the next insertion.
- Simultaneous events:
  - Accepted fall and a key in the same cycle: the fall wins and the key is dropped.
  - `card_bit_valid` outside READ: ignored.
  - `key_valid` outside ACTIVE: ignored.
- Reset mid-operation: immediate return to reset values; a partially read frame is discarded.
- Counter widths: bit counter 4 bits; timeout counter `$clog2(READ_TIMEOUT+1)` bits, saturating.

Decomposition:
- Shared package `atm_pkg`:
  - FSM state encoding for IDLE, READ, ACTIVE, ERROR.
  - `read_error` codes.
  - Key code constants KEY_CLEAR=4'hA and KEY_ENTER=4'hB.
  - Card frame length (9).
- Sub-module `atm_debounce`: parameterised level debouncer with outputs `level` and `rise`/`fall` pulses. It is instantiated once for `card_present`.

Test Plan:
- Good read:
  - Stimulus: `card_present` high for 4 cycles, then frame for card 0x05 (bits 1,0,1,0,0,0,0,0, parity 1).
  - Response: `card_number`=0x05, `card_inserted`=1 one cycle after the 9th bit, `read_error`=0.
- Parity fail:
  - Stimulus: frame for 0x05 with parity bit 0.
  - Response: `read_error`=1, `card_inserted` stays 0; removal returns to IDLE.
- Timeout:
  - Stimulus: insert, send 3 bits, then stall 64 cycles.
  - Response: `read_error`=2, ERROR state, `card_inserted`=0.
- PIN entry:
  - Stimulus: keys 1,2,3,4,5,ENTER.
  - Response: `pin_value`=16'h1234 (digit 5 ignored), `pin_ready` high for exactly 1 cycle, `digit_count`=0.
- Short PIN and CLEAR:
  - Stimulus: keys 9,8,ENTER.
  - Response: `read_error`=3, `pin_value`=0.
  - Stimulus: keys 7,CLEAR,4,3,2,1,ENTER.
  - Response: `pin_value`=16'h4321 with `pin_ready`.
- Bounce and removal:
  - Stimulus: `card_present` toggles 1,1,0,1,1,1,1.
  - Response: accepted only after the final 4 stable cycles.
  - Stimulus: in ACTIVE, drop `card_present` for 4 cycles while pressing key 6.
  - Response: key dropped, IDLE, all outputs cleared except `read_error`.
